lut_logic_unit: RTL



---
 rtl/lut_logic_unit_pkg.sv | 23 ++
 rtl/lut_out_reg.sv | 33 +++
 rtl/lut_logic_unit.sv | 116 +++++++++++
 3 files changed

// File: rtl/lut_logic_unit_pkg.sv
// Shared definitions for the programmable LUT logic unit: state encoding,
// default geometry and a constant-friendly ceil(log2) for sizing counters.
package lut_logic_unit_pkg;

    localparam int DEF_IN_W  = 4;
    localparam int DEF_OUT_W = 5;

    typedef enum logic [1:0] {
        ST_UNCFG = 2'd0,
        ST_LOAD  = 2'd1,
        ST_READY = 2'd2
    } state_t;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            result++;
        end
        return result;
    endfunction

endpackage

// File: rtl/lut_out_reg.sv
// Single-entry valid/ready output register; in_valid must already be qualified
// by the upstream enable, the register only adds its own space check.
module lut_out_reg #(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    output logic         in_ready,
    output logic         out_valid,
    output logic [W-1:0] out_data,
    input  logic         out_ready
);

    // Space exists when empty or when the current entry leaves this cycle.
    assign in_ready = !out_valid || out_ready;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (in_valid && in_ready) begin
            out_valid <= 1'b1;
            out_data  <= in_data;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/lut_logic_unit.sv
// Programmable truth table: serially loaded flop table, one lookup (or bypass)
// per cycle into a valid/ready output register.
module lut_logic_unit
    import lut_logic_unit_pkg::*;
#(
    parameter int IN_W  = DEF_IN_W,
    parameter int OUT_W = DEF_OUT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_start,
    input  logic             cfg_valid,
    input  logic             cfg_bit,
    output logic             cfg_busy,
    output logic             cfg_done,
    output logic             configured,
    input  logic             mode_pass,
    input  logic             in_valid,
    input  logic [IN_W-1:0]  in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [OUT_W-1:0] out_data,
    input  logic             out_ready
);

    localparam int DEPTH    = 1 << IN_W;
    localparam int TBL_BITS = DEPTH * OUT_W;
    localparam int CNT_W    = clog2(TBL_BITS);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(TBL_BITS - 1);

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q;
    logic [TBL_BITS-1:0] table_q;
    logic                lookup_en;
    logic                reg_ready;
    logic                accept;
    logic                last_write;
    logic [OUT_W-1:0]    lut_word;
    logic [OUT_W-1:0]    result;
    logic [IN_W+OUT_W-1:0] pass_ext;

    assign last_write = (state_q == ST_LOAD) && cfg_valid && (cnt_q == LAST_BIT);

    // NOTE: every combinational output gets a default first so no path
    // through the case leaves a signal unassigned (no latches).
    always_comb begin
        state_d   = state_q;
        lookup_en = 1'b0;
        case (state_q)
            ST_UNCFG: begin
                lookup_en = mode_pass;
                if (cfg_start && !out_valid) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                if (last_write) state_d = ST_READY;
            end
            ST_READY: begin
                lookup_en = 1'b1;
                if (cfg_start && !out_valid) state_d = ST_LOAD;
            end
            default: state_d = ST_UNCFG;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_UNCFG;
        else        state_q <= state_d;
    end

    // NOTE: the table is plain flops with an async clear so a reset mid-load
    // never leaves a partial table behind; it must not map to RAM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            table_q    <= '0;
            cnt_q      <= '0;
            configured <= 1'b0;
            cfg_done   <= 1'b0;
        end else begin
            cfg_done <= last_write;
            if (state_q == ST_LOAD && cfg_valid) begin
                table_q[cnt_q] <= cfg_bit;
                cnt_q          <= last_write ? '0 : cnt_q + CNT_W'(1);
            end
            if (state_q != ST_LOAD && state_d == ST_LOAD) configured <= 1'b0;
            else if (last_write)                          configured <= 1'b1;
        end
    end

    assign cfg_busy = (state_q == ST_LOAD);

    always_comb begin
        lut_word = '0;
        for (int e = 0; e < DEPTH; e++) begin
            if (in_data == IN_W'(e)) lut_word = table_q[e*OUT_W +: OUT_W];
        end
    end

    // Bypass zero-extends or truncates the input vector to the output width.
    assign pass_ext = {{OUT_W{1'b0}}, in_data};
    assign result   = mode_pass ? pass_ext[OUT_W-1:0] : lut_word;

    assign in_ready = lookup_en && reg_ready;
    assign accept   = in_valid && in_ready;

    lut_out_reg #(.W(OUT_W)) u_out_reg (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (accept),
        .in_data   (result),
        .in_ready  (reg_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready)
    );

endmodule
